rst_req_gen: RTL and testbench
==============================

RST_REQ_GEN -- requirements
Module: rst_req_gen

Interface
REQ-001 Parameter NUM_STAGES, default 2, SHALL set the depth of the feedback synchronizer on SYNC_RST_FB (legal range 2..8).
REQ-002 Parameter HOLD_CYCLES, default 4, SHALL set the minimum number of clock cycles RST_OUT is held low (legal range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles spent in a wait state before abort (legal range 2..1023).
REQ-004 CLK  input  1  single clock; all state is updated on its rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-low.
REQ-006 RST_REQ  input  1  reset-sequence request, level-sensitive, synchronous to CLK.
REQ-007 SYNC_RST_FB  input  1  feedback from the SYNC_RST output of the remote reset synchronizer, active-low, asynchronous to CLK.
REQ-008 RST_OUT  output  1  active-low reset driven to the remote synchronizer's RST input, registered.
REQ-009 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-010 DONE  output  1  one-cycle high pulse when a sequence completes.
REQ-011 TIMEOUT_ERR  output  1  sticky error flag (see Configuration).

Function
REQ-012 States SHALL be IDLE, ASSERT, WAIT_LOW, RELEASE, WAIT_HIGH and FINISH.
REQ-013 SYNC_RST_FB SHALL pass through NUM_STAGES flops; the last stage (FB_S) is the only feedback the FSM uses.
REQ-014 IDLE: RST_OUT=1; when RST_REQ=1 at an edge, go to ASSERT; RST_OUT=0 from that edge.
REQ-015 ASSERT: RST_OUT=0 and a hold counter counts up; after HOLD_CYCLES cycles in ASSERT, go to WAIT_LOW.
REQ-016 WAIT_LOW: RST_OUT=0; when FB_S=0, go to RELEASE.
REQ-017 RELEASE: RST_OUT=1 from this edge; lasts one cycle, then go to WAIT_HIGH.
REQ-018 WAIT_HIGH: RST_OUT=1; when FB_S=1, go to FINISH.
REQ-019 FINISH: DONE=1 for exactly this cycle, then go to IDLE.
REQ-020 RST_OUT SHALL be low for at least HOLD_CYCLES consecutive cycles per sequence, and SHALL stay low until the synchronized feedback confirms assertion.
REQ-021 RST_REQ SHALL be ignored outside IDLE; if RST_REQ is held high, sequences run back-to-back with exactly one IDLE cycle between FINISH and the next ASSERT.
REQ-022 Counters SHALL be sized with $clog2 of their maximum plus 1; they SHALL saturate and never wrap.
REQ-023 A glitch on SYNC_RST_FB shorter than one cycle in IDLE SHALL have no effect on any output.

Reset
REQ-024 On RST=0, asynchronously: the FSM goes to ASSERT, RST_OUT=0, all synchronizer stages=0, counters=0, BUSY=1, DONE=0, TIMEOUT_ERR=0.
REQ-025 After RST is released, the block SHALL run a full power-on sequence with no request; DONE pulses at its end.
REQ-026 RST asserted mid-sequence SHALL restart the sequence from ASSERT, with the hold count restarting at 0.

Configuration
REQ-027 Macro RST_REQ_GEN_TIMEOUT_EN: when defined, a wait counter runs in WAIT_LOW and WAIT_HIGH; if it reaches TIMEOUT_CYCLES, TIMEOUT_ERR is set (sticky until RST), RST_OUT=1, the FSM goes to IDLE and DONE does not pulse.
REQ-028 Without RST_REQ_GEN_TIMEOUT_EN: the wait states wait indefinitely and TIMEOUT_ERR is tied to 0; the port list is unchanged.

Verification
REQ-029 Bench: CLK period 100 ns; a remote reset synchronizer model with NUM_STAGES=3 on the same CLK, looped back RST_OUT -> RST -> SYNC_RST -> SYNC_RST_FB.
REQ-030 Power-on: release RST at 150 ns -> RST_OUT low for >=4 cycles; DONE pulses once; BUSY=0 afterward; RST_OUT=1.
REQ-031 Single request: RST_REQ one-cycle pulse in IDLE -> RST_OUT low on the next edge for >=HOLD_CYCLES+1 cycles; DONE one cycle high; RST_OUT never low again.
REQ-032 Held request: RST_REQ=1 for 100 cycles -> repeated sequences, exactly one IDLE cycle between each DONE and the next RST_OUT fall.
REQ-033 Mid-sequence reset: pulse RST low in WAIT_HIGH -> RST_OUT=0 immediately (asynchronous); full sequence reruns; exactly one DONE.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=16): hold SYNC_RST_FB=1 -> after 4+16 cycles TIMEOUT_ERR=1 and stays 1, RST_OUT=1, no DONE; without the macro, BUSY stays 1 and TIMEOUT_ERR=0.

Source files
------------

// File: rtl/rst_req_gen.sv
// Reset-request sequencer: drives a remote synchronizer's reset low and waits on its feedback.
// Optional macro RST_REQ_GEN_TIMEOUT_EN aborts a stuck wait state after TIMEOUT_CYCLES.
module rst_req_gen #(
  parameter int NUM_STAGES     = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_req,
  input  logic sync_rst_fb,
  output logic rst_out,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ASSERT    = 3'd1,
    WAIT_LOW  = 3'd2,
    RELEASE   = 3'd3,
    WAIT_HIGH = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t                state_reg, state_next;
  logic [NUM_STAGES-1:0] fb_sync_reg;
  logic                  fb_s;
  logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
  logic                  hold_done;
  logic                  rst_out_reg, rst_out_next;
  logic                  timeout_hit;

  generate
    if (NUM_STAGES < 2 || NUM_STAGES > 8 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_params
      $error("rst_req_gen: parameter out of legal range");
    end
  endgenerate

  // Feedback is asynchronous to clk; only the last stage is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fb_sync_reg <= '0;
    else        fb_sync_reg <= {fb_sync_reg[NUM_STAGES-2:0], sync_rst_fb};
  end
  assign fb_s = fb_sync_reg[NUM_STAGES-1];

  assign hold_done = (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1));

  always_comb begin
    hold_cnt_next = '0;
    if (state_reg == ASSERT && hold_cnt_reg != HOLD_W'(HOLD_CYCLES))
      hold_cnt_next = hold_cnt_reg + 1'b1;
  end

`ifdef RST_REQ_GEN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              in_wait;

  assign in_wait     = (state_reg == WAIT_LOW) || (state_reg == WAIT_HIGH);
  assign timeout_hit = in_wait && (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Count restarts whenever the wait state is left or changes.
  always_comb begin
    wait_cnt_next = '0;
    if (in_wait && state_next == state_reg && wait_cnt_reg != WAIT_W'(TIMEOUT_CYCLES))
      wait_cnt_next = wait_cnt_reg + 1'b1;
    timeout_err_next = timeout_err_reg | (in_wait && state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Reset lands in ASSERT so a power-on sequence runs without a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ASSERT;
      hold_cnt_reg <= '0;
      rst_out_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      rst_out_reg  <= rst_out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (rst_req) state_next = ASSERT;
      ASSERT:    if (hold_done) state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (!fb_s)            state_next = RELEASE;
        else if (timeout_hit) state_next = IDLE;
      end
      RELEASE:   state_next = WAIT_HIGH;
      WAIT_HIGH: begin
        if (fb_s)             state_next = FINISH;
        else if (timeout_hit) state_next = IDLE;
      end
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // rst_out is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    rst_out_next = 1'b1;
    if (state_next == ASSERT || state_next == WAIT_LOW) rst_out_next = 1'b0;
    busy = (state_reg != IDLE);
    done = (state_reg == FINISH);
  end

  assign rst_out = rst_out_reg;

endmodule

// File: tb/tb_rst_req_gen.sv
// Self-checking bench for rst_req_gen with a 3-stage remote synchronizer looped back.
// Honours RST_REQ_GEN_TIMEOUT_EN the same way as the design.
module tb_rst_req_gen;
  localparam int NS   = 2;
  localparam int HOLD = 4;
  localparam int TMO  = 16;

  logic clk = 1'b1;
  logic rst_n = 1'b1;
  logic rst_req = 1'b0;
  logic sync_rst_fb;
  logic rst_out, busy, done, timeout_err;
  logic [2:0] remote_sync;
  logic fb_ovr = 1'b0;
  logic fb_val = 1'b1;
  logic [3:0] obs;
  int checks = 0;
  int failures = 0;

  always #50 clk = ~clk;

  // Remote reset synchronizer: async reset by rst_out, shifts ones in.
  always_ff @(posedge clk or negedge rst_out) begin
    if (!rst_out) remote_sync <= '0;
    else          remote_sync <= {remote_sync[1:0], 1'b1};
  end
  assign sync_rst_fb = fb_ovr ? fb_val : remote_sync[2];
  assign obs = {rst_out, busy, done, timeout_err};

  rst_req_gen #(.NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .sync_rst_fb(sync_rst_fb),
    .rst_out(rst_out), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: {rst_out,busy,done,err} got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference model: timestamps of sequence start, release and finish.
  bit raw_hist [0:511];
  bit m_active, m_rel_ok, m_fin_ok;
  int m_start, m_rel, m_fin;

  function automatic bit fbs(input int k);
    if (k - NS + 1 < 0) return 1'b0;
    return raw_hist[k - NS + 1];
  endfunction

  // Predict outputs of cycle n from the request sampled at edge n and fb_s of cycle n-1.
  task automatic model_step(input int n, input bit req, input bit fb_prev, output logic [3:0] exp);
    if (!m_active) begin
      if (req) begin
        m_active = 1'b1; m_start = n; m_rel_ok = 1'b0; m_fin_ok = 1'b0;
      end
    end else if (m_fin_ok && n == m_fin + 1) begin
      m_active = 1'b0;
    end else if (!m_rel_ok) begin
      if (n - 1 >= m_start + HOLD && !fb_prev) begin m_rel_ok = 1'b1; m_rel = n; end
    end else if (!m_fin_ok) begin
      if (n - 1 >= m_rel + 1 && fb_prev) begin m_fin_ok = 1'b1; m_fin = n; end
    end
    if (!m_active) exp = 4'b1000;
    else           exp = {m_rel_ok, 1'b1, (m_fin_ok && n == m_fin), 1'b0};
  endtask

  typedef struct packed {
    logic       req;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp;
    logic [3:0] exp_after;
    int po_dones, po_low, held_dones, last_done, low, dones;
    bit prev_ro, seen_high;

    tbl[0]  = '{1'b1, 4'b0100}; tbl[1]  = '{1'b0, 4'b0100};
    tbl[2]  = '{1'b0, 4'b0100}; tbl[3]  = '{1'b1, 4'b0100};
    tbl[4]  = '{1'b0, 4'b0100}; tbl[5]  = '{1'b0, 4'b1100};
    tbl[6]  = '{1'b0, 4'b1100}; tbl[7]  = '{1'b0, 4'b1100};
    tbl[8]  = '{1'b1, 4'b1100}; tbl[9]  = '{1'b0, 4'b1100};
    tbl[10] = '{1'b0, 4'b1100}; tbl[11] = '{1'b1, 4'b1110};
    tbl[12] = '{1'b1, 4'b1000}; tbl[13] = '{1'b0, 4'b1000};

    #1 rst_n = 1'b0;
    #9 check("reset_state", obs, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-on then randomized requests, cycle-by-cycle against the model.
    m_active = 1'b1; m_start = -1; m_rel_ok = 1'b0; m_fin_ok = 1'b0;
    exp = 4'b0100; po_dones = 0; po_low = 0;
    for (int k = -1; k < 420; k++) begin
      check($sformatf("model_c%0d", k), obs, exp);
      if (k < 20) begin
        if (done) po_dones++;
        if (!rst_out) po_low++;
      end
      if (k == 19) begin
        check_int("poweron_dones", po_dones, 1);
        check_int("poweron_low_ge4", int'(po_low >= 4), 1);
        check("poweron_idle", obs, 4'b1000);
        $display("poweron: dones=%0d low_cycles=%0d", po_dones, po_low);
      end
      raw_hist[k + 1] = sync_rst_fb;
      rst_req = (k >= 19 && k < 418) ? ($urandom_range(0, 3) == 0) : 1'b0;
      model_step(k + 1, rst_req, fbs(k), exp);
      @(negedge clk);
    end
    rst_req = 1'b0;
    $display("random: %0d cycles compared against model", 421);
    wait_idle("random_idle");

    // Single request, with requests outside IDLE ignored.
    for (int i = 0; i < 14; i++) begin
      rst_req = tbl[i].req;
      @(negedge clk);
      check($sformatf("table_%0d", i), obs, tbl[i].exp);
      $display("vec %0d req=%b obs=%b", i, tbl[i].req, obs);
    end
    rst_req = 1'b0;
    wait_idle("table_idle");

    // Held request: back-to-back sequences with one IDLE cycle between.
    rst_req = 1'b1;
    held_dones = 0; last_done = -100; prev_ro = rst_out;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin held_dones++; last_done = i; end
      if (prev_ro && !rst_out && last_done >= 0) check_int("held_gap", i - last_done, 2);
      prev_ro = rst_out;
    end
    rst_req = 1'b0;
    check_int("held_dones", held_dones, 7);
    $display("held: dones=%0d", held_dones);
    wait_idle("held_idle");

    // Sub-cycle glitch on the feedback while idle.
    @(negedge clk);
    #40 fb_ovr = 1'b1; fb_val = 1'b0;
    #20 fb_ovr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("glitch_%0d", i), obs, 4'b1000);
    end
    $display("glitch: outputs held idle");

    // Asynchronous reset in WAIT_HIGH restarts the sequence.
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst_pre", obs, 4'b1100);
    #10 rst_n = 1'b0;
    #1 check("midrst_async", obs, 4'b0100);
    #19 rst_n = 1'b1;
    low = 0; dones = 0; seen_high = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rst_out) seen_high = 1'b1;
      else if (!seen_high) low++;
      if (done) dones++;
    end
    check_int("midrst_low", low, 4);
    check_int("midrst_dones", dones, 1);
    check("midrst_end", obs, 4'b1000);
    $display("midrst: low=%0d dones=%0d", low, dones);

    // Feedback stuck high: timeout abort or indefinite wait.
    fb_ovr = 1'b1; fb_val = 1'b1;
    @(negedge clk);
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    for (int i = 0; i < 26; i++) begin
`ifdef RST_REQ_GEN_TIMEOUT_EN
      exp = (i < HOLD + TMO) ? 4'b0100 : 4'b1001;
`else
      exp = 4'b0100;
`endif
      check($sformatf("timeout_c%0d", i), obs, exp);
      @(negedge clk);
    end
`ifdef RST_REQ_GEN_TIMEOUT_EN
    exp_after = 4'b1001;
`else
    exp_after = 4'b1000;
`endif
    fb_ovr = 1'b0;
    repeat (4) @(negedge clk);
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    wait_idle("timeout_recover");
    check("timeout_sticky", obs, exp_after);
    $display("timeout: obs=%b", obs);

    #10 rst_n = 1'b0;
    #10 check("reset_clears_err", obs, 4'b0100);
    #10 rst_n = 1'b1;
    wait_idle("final_idle");
    check("final_state", obs, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
